mem_access_unit: RTL

- Load/store stage directly downstream of the ExecutionUnit.
- Consumes the ALU result (effective address or arithmetic result), store data and destination register from EX.
- Performs byte/half/word data-memory accesses over a req/ack handshake with alignment and timeout checking.
- Presents one registered writeback record per accepted instruction to the register-file write port.

---
 rtl/mpc_mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mpc_mem_pkg.sv
// Shared encodings and helpers for the load/store stage.
package mpc_mem_pkg;

  // Access size encodings carried on iSize.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Width of the ack timeout counter.
  localparam int TO_CNT_W = 8;

  // Access state machine encodings.
  typedef enum logic [0:0] {
    MAU_IDLE = 1'b0,
    MAU_REQ  = 1'b1
  } mau_state_e;

  // True when the access cannot be issued at this byte offset.
  // The reserved size encoding is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = (off != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module mem_lane_align
  import mpc_mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sext,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: byte enables and replicated write data for the addressed lanes.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_st_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SIZE_HALF: begin
        o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      SIZE_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed lane from the read word and extend it.
  always_comb begin
    w_shift   = i_ld_rdata >> {i_ld_off, 3'b000};
    w_byte    = w_shift[7:0];
    w_half    = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SIZE_BYTE: begin
        if (i_ld_sext) begin
          o_ld_data = {{24{w_byte[7]}}, w_byte};
        end else begin
          o_ld_data = {24'h00_0000, w_byte};
        end
      end
      SIZE_HALF: begin
        if (i_ld_sext) begin
          o_ld_data = {{16{w_half[15]}}, w_half};
        end else begin
          o_ld_data = {16'h0000, w_half};
        end
      end
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: issues data-memory accesses over req/ack, checks
// alignment and ack timeout, and emits one writeback record per instruction.
module mem_access_unit
  import mpc_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      iValid,
  input  logic [DATA_WIDTH-1:0]     iALUOut,
  input  logic [DATA_WIDTH-1:0]     iStoreData,
  input  logic [REG_ADDR_WIDTH-1:0] iRd,
  input  logic                      iRegWr,
  input  logic                      iMemRd,
  input  logic                      iMemWr,
  input  logic [1:0]                iSize,
  input  logic                      iSignExt,
  output logic                      oBusy,
  output logic                      oDmemReq,
  output logic                      oDmemWe,
  output logic [ADDR_WIDTH-1:0]     oDmemAddr,
  output logic [3:0]                oDmemBe,
  output logic [DATA_WIDTH-1:0]     oDmemWData,
  input  logic                      iDmemAck,
  input  logic [DATA_WIDTH-1:0]     iDmemRData,
  output logic                      oWbValid,
  output logic                      oWbRegWr,
  output logic [REG_ADDR_WIDTH-1:0] oWbRd,
  output logic [DATA_WIDTH-1:0]     oWbData,
  output logic                      oAlignErr,
  output logic                      oBusErr
);

  mau_state_e r_state, w_next;

  logic [TO_CNT_W-1:0]       r_cnt;
  logic                      r_req, r_we, r_is_load, r_sext, r_regwr;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [3:0]                r_be;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [1:0]                r_size, r_off;
  logic                      r_wb_valid, r_wb_regwr, r_align_err, r_bus_err;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]     r_wb_data;

  logic                      w_accept, w_mem, w_mis, w_timeout;
  logic [3:0]                w_be;
  logic [31:0]               w_wdata, w_ld_data;

  assign w_accept  = iValid && (r_state == MAU_IDLE);
  assign w_mem     = iMemRd || iMemWr;
  assign w_mis     = is_misaligned(iSize, iALUOut[1:0]);
  // The error fires on the cycle the counter sits at TIMEOUT with no ack,
  // so an ack arriving in that same cycle still retires normally.
  assign w_timeout = (r_cnt == TO_CNT_W'(TIMEOUT));

  mem_lane_align u_lane (
    .i_st_size  (iSize),
    .i_st_off   (iALUOut[1:0]),
    .i_st_data  (iStoreData),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_sext  (r_sext),
    .i_ld_rdata (iDmemRData),
    .o_ld_data  (w_ld_data)
  );

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= MAU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: enter REQ on an aligned memory op, leave on ack or timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MAU_IDLE: begin
        if (w_accept && w_mem && !w_mis) begin
          w_next = MAU_REQ;
        end else begin
          w_next = MAU_IDLE;
        end
      end
      MAU_REQ: begin
        if (iDmemAck || w_timeout) begin
          w_next = MAU_IDLE;
        end else begin
          w_next = MAU_REQ;
        end
      end
      default: w_next = MAU_IDLE;
    endcase
  end

  // Stall upstream for the whole time an access is outstanding.
  always_comb begin
    oBusy = (r_state == MAU_REQ);
  end

  // Datapath: operand capture, bus request, timeout counter, writeback record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
      r_sext      <= 1'b0;
      r_regwr     <= 1'b0;
      r_addr      <= '0;
      r_be        <= 4'b0000;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wb_valid  <= 1'b0;
      r_wb_regwr  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
      r_wb_regwr  <= 1'b0;
      case (r_state)
        MAU_IDLE: begin
          if (w_accept) begin
            if (!w_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= iALUOut;
              r_wb_rd    <= iRd;
              r_wb_regwr <= iRegWr && (iRd != '0);
            end else if (w_mis) begin
              r_wb_valid  <= 1'b1;
              r_align_err <= 1'b1;
              r_wb_data   <= iALUOut;
              r_wb_rd     <= iRd;
            end else begin
              r_req     <= 1'b1;
              r_we      <= iMemWr;
              r_addr    <= {iALUOut[ADDR_WIDTH-1:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_rd      <= iRd;
              r_regwr   <= iRegWr;
              r_is_load <= !iMemWr;
              r_sext    <= iSignExt;
              r_size    <= iSize;
              r_off     <= iALUOut[1:0];
              r_cnt     <= '0;
            end
          end
        end
        MAU_REQ: begin
          if (iDmemAck) begin
            r_req      <= 1'b0;
            r_cnt      <= '0;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            if (r_is_load) begin
              r_wb_data  <= w_ld_data;
              r_wb_regwr <= r_regwr && (r_rd != '0);
            end
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_cnt      <= '0;
            r_wb_valid <= 1'b1;
            r_bus_err  <= 1'b1;
            r_wb_rd    <= r_rd;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_req <= 1'b0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign oDmemReq   = r_req;
  assign oDmemWe    = r_we;
  assign oDmemAddr  = r_addr;
  assign oDmemBe    = r_be;
  assign oDmemWData = r_wdata;
  assign oWbValid   = r_wb_valid;
  assign oWbRegWr   = r_wb_regwr;
  assign oWbRd      = r_wb_rd;
  assign oWbData    = r_wb_data;
  assign oAlignErr  = r_align_err;
  assign oBusErr    = r_bus_err;

endmodule
